sprite_animator: RTL and testbench

SPRITE_ANIMATOR -- requirements
Module: sprite_animator

---
 rtl/sprite_animator.sv | 152 +++++++++++++++
 tb/tb_sprite_animator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_animator.sv
// Single-troop sprite animator: spawns, walks toward a target row, loops an attack,
// and plays a one-shot death. Sprite outputs only update on the cycle after new_frame.
module sprite_animator #(
    parameter int FRAME_HOLD   = 4,
    parameter int SPEED        = 2,
    parameter int WALK_FIRST   = 0,
    parameter int WALK_LAST    = 7,
    parameter int ATTACK_FIRST = 8,
    parameter int ATTACK_LAST  = 15,
    parameter int DEATH_FIRST  = 16,
    parameter int DEATH_LAST   = 22
) (
    input  logic        clk_pixel,
    input  logic        sys_rst,
    input  logic        new_frame,
    input  logic        spawn,
    input  logic [10:0] spawn_x,
    input  logic [9:0]  spawn_y,
    input  logic [9:0]  target_y,
    input  logic        kill,
    output logic        sprite_valid,
    output logic [10:0] sprite_x,
    output logic [9:0]  sprite_y,
    output logic [4:0]  sprite_frame_number,
    output logic        busy
);
    localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(FRAME_HOLD - 1);
    localparam logic [9:0]    SPD      = 10'(SPEED);

    typedef enum logic [1:0] {IDLE, WALK, ATTACK, DEATH} state_e;

    state_e          state_q;
    logic [HW-1:0]   hold_q;
    logic [4:0]      frame_q;
    logic            valid_q;
    logic [10:0]     x_q, spawn_x_q;
    logic [9:0]      y_q, spawn_y_q, tgt_q;
    logic            spawn_pend_q, kill_pend_q;

    logic [9:0]      y_d;
    logic [4:0]      frame_d;
    logic            hold_wrap;

    assign hold_wrap = (hold_q == HOLD_MAX);

    // One SPEED step toward the target, clamped so it never overshoots.
    always_comb begin
        y_d = y_q;
        if (y_q < tgt_q) begin
            if ((tgt_q - y_q) < SPD) y_d = tgt_q;
            else                     y_d = y_q + SPD;
        end else if (y_q > tgt_q) begin
            if ((y_q - tgt_q) < SPD) y_d = tgt_q;
            else                     y_d = y_q - SPD;
        end
    end

    always_comb begin
        frame_d = frame_q + 5'd1;
        case (state_q)
            WALK:    if (frame_q == 5'(WALK_LAST))   frame_d = 5'(WALK_FIRST);
            ATTACK:  if (frame_q == 5'(ATTACK_LAST)) frame_d = 5'(ATTACK_FIRST);
            default: ;
        endcase
    end

    always_ff @(posedge clk_pixel) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            frame_q      <= '0;
            valid_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            spawn_x_q    <= '0;
            spawn_y_q    <= '0;
            tgt_q        <= '0;
            spawn_pend_q <= 1'b0;
            kill_pend_q  <= 1'b0;
        end else begin
            if (spawn && state_q == IDLE && !spawn_pend_q) begin
                spawn_x_q    <= spawn_x;
                spawn_y_q    <= spawn_y;
                tgt_q        <= target_y;
                spawn_pend_q <= 1'b1;
            end
            if (kill && (state_q == WALK || state_q == ATTACK))
                kill_pend_q <= 1'b1;

            // Frame-boundary updates use the pending flags as they stood before this cycle,
            // so a spawn or kill coinciding with new_frame lands on the next frame.
            if (new_frame) begin
                case (state_q)
                    IDLE: begin
                        if (spawn_pend_q) begin
                            state_q      <= WALK;
                            x_q          <= spawn_x_q;
                            y_q          <= spawn_y_q;
                            frame_q      <= 5'(WALK_FIRST);
                            hold_q       <= '0;
                            valid_q      <= 1'b1;
                            spawn_pend_q <= 1'b0;
                        end
                    end
                    WALK, ATTACK: begin
                        if (kill_pend_q) begin
                            state_q     <= DEATH;
                            frame_q     <= 5'(DEATH_FIRST);
                            hold_q      <= '0;
                            kill_pend_q <= 1'b0;
                        end else if (state_q == WALK && y_q == tgt_q) begin
                            state_q <= ATTACK;
                            frame_q <= 5'(ATTACK_FIRST);
                            hold_q  <= '0;
                        end else begin
                            if (state_q == WALK) y_q <= y_d;
                            if (hold_wrap) begin
                                hold_q  <= '0;
                                frame_q <= frame_d;
                            end else begin
                                hold_q <= hold_q + 1'b1;
                            end
                        end
                    end
                    DEATH: begin
                        if (hold_wrap && frame_q == 5'(DEATH_LAST)) begin
                            state_q <= IDLE;
                            hold_q  <= '0;
                            frame_q <= '0;
                            valid_q <= 1'b0;
                            x_q     <= '0;
                            y_q     <= '0;
                        end else if (hold_wrap) begin
                            hold_q  <= '0;
                            frame_q <= frame_d;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sprite_valid        = valid_q;
    assign sprite_x            = x_q;
    assign sprite_y            = y_q;
    assign sprite_frame_number = frame_q;
    assign busy                = (state_q != IDLE) || spawn_pend_q;
endmodule

// File: tb/tb_sprite_animator.sv
module tb_sprite_animator;
    logic        clk_pixel = 1'b0;
    logic        sys_rst = 1'b1;
    logic        new_frame = 1'b0;
    logic        spawn = 1'b0;
    logic [10:0] spawn_x = '0;
    logic [9:0]  spawn_y = '0;
    logic [9:0]  target_y = '0;
    logic        kill = 1'b0;
    logic        sprite_valid;
    logic [10:0] sprite_x;
    logic [9:0]  sprite_y;
    logic [4:0]  sprite_frame_number;
    logic        busy;

    sprite_animator dut (
        .clk_pixel(clk_pixel), .sys_rst(sys_rst), .new_frame(new_frame),
        .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y), .target_y(target_y),
        .kill(kill), .sprite_valid(sprite_valid), .sprite_x(sprite_x),
        .sprite_y(sprite_y), .sprite_frame_number(sprite_frame_number), .busy(busy)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        string       name;
        logic        v;
        logic [10:0] x;
        logic [9:0]  y;
        logic [4:0]  f;
        logic        b;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int tests = 0;
    int fails = 0;

    always @(negedge clk_pixel) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (sprite_valid !== e.v || sprite_x !== e.x || sprite_y !== e.y ||
                sprite_frame_number !== e.f || busy !== e.b) begin
                fails++;
                $display("FAIL %s: got v=%0b x=%0d y=%0d f=%0d busy=%0b, want v=%0b x=%0d y=%0d f=%0d busy=%0b",
                         e.name, sprite_valid, sprite_x, sprite_y, sprite_frame_number, busy,
                         e.v, e.x, e.y, e.f, e.b);
            end
        end
    end

    initial begin
        #2000000;
        tests++;
        fails++;
        $display("FAIL timeout: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic chk_idle(input string n);
        tests++;
        if (sprite_valid !== 1'b0 || sprite_x !== 11'd0 || sprite_y !== 10'd0 ||
            sprite_frame_number !== 5'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: got v=%0b x=%0d y=%0d f=%0d busy=%0b, want all zero",
                     n, sprite_valid, sprite_x, sprite_y, sprite_frame_number, busy);
        end
    endtask

    task automatic ex(input string n, input logic v, input logic [10:0] x,
                      input logic [9:0] y, input logic [4:0] f, input logic b);
        exp_t t;
        t.name = n; t.v = v; t.x = x; t.y = y; t.f = f; t.b = b;
        q.push_back(t);
    endtask

    task automatic cyc();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic nf();
        new_frame = 1'b1;
        cyc();
        new_frame = 1'b0;
    endtask

    task automatic do_spawn(input logic [10:0] x, input logic [9:0] y, input logic [9:0] t,
                            input logic with_nf);
        spawn = 1'b1; spawn_x = x; spawn_y = y; target_y = t; new_frame = with_nf;
        cyc();
        spawn = 1'b0; new_frame = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        cyc();
        sys_rst = 1'b0;
    endtask

    initial begin
        #1;
        cyc(); cyc();
        sys_rst = 1'b0;
        chk_idle("reset_direct");
        ex("reset", 0, 0, 0, 0, 0);
        nf();
        ex("reset_nf_idle", 0, 0, 0, 0, 0);

        do_spawn(100, 200, 100, 0);
        ex("spawn_pending", 0, 0, 0, 0, 1);
        cyc();
        ex("pending_no_nf", 0, 0, 0, 0, 1);
        nf();
        ex("walk_start", 1, 100, 200, 0, 1);
        for (int i = 1; i <= 50; i++) begin
            nf();
            ex($sformatf("walk_%0d", i), 1, 100, 10'(200 - 2*i), 5'((i/4) % 8), 1);
            if (i == 10) begin
                cyc(); cyc();
                ex("walk_stable", 1, 100, 180, 2, 1);
            end
        end
        nf();
        ex("attack_enter", 1, 100, 100, 8, 1);
        for (int i = 1; i <= 32; i++) begin
            nf();
            ex($sformatf("attack_%0d", i), 1, 100, 100, 5'(8 + (i/4) % 8), 1);
        end

        sys_rst = 1'b1; new_frame = 1'b1; kill = 1'b1;
        cyc();
        sys_rst = 1'b0; new_frame = 1'b0; kill = 1'b0;
        chk_idle("reset_attack_direct");
        ex("reset_attack", 0, 0, 0, 0, 0);
        nf();
        ex("reset_attack_nf", 0, 0, 0, 0, 0);

        do_spawn(33, 201, 100, 1);
        ex("simul_spawn", 0, 0, 0, 0, 1);
        nf();
        ex("clamp_start", 1, 33, 201, 0, 1);
        for (int i = 1; i <= 50; i++) begin
            nf();
            ex($sformatf("clamp_%0d", i), 1, 33, 10'(201 - 2*i), 5'((i/4) % 8), 1);
        end
        nf();
        ex("clamp_final", 1, 33, 100, 4, 1);
        nf();
        ex("clamp_attack", 1, 33, 100, 8, 1);

        do_reset();
        chk_idle("reset2_direct");
        ex("reset2", 0, 0, 0, 0, 0);
        do_spawn(50, 300, 310, 0);
        nf();
        ex("up_start", 1, 50, 300, 0, 1);
        nf(); nf(); nf();
        ex("up_3", 1, 50, 306, 0, 1);
        kill = 1'b1;
        cyc();
        kill = 1'b0;
        ex("kill_no_change", 1, 50, 306, 0, 1);
        nf();
        ex("death_enter", 1, 50, 306, 16, 1);
        do_spawn(7, 7, 7, 0);
        ex("spawn_in_death", 1, 50, 306, 16, 1);
        for (int i = 1; i <= 28; i++) begin
            nf();
            if (i < 28) ex($sformatf("death_%0d", i), 1, 50, 306, 5'(16 + i/4), 1);
            else        ex("death_idle", 0, 0, 0, 0, 0);
        end
        nf();
        ex("death_spawn_ignored", 0, 0, 0, 0, 0);

        kill = 1'b1;
        cyc();
        kill = 1'b0;
        do_spawn(1, 10, 10, 0);
        nf();
        ex("idle_kill_ignored", 1, 1, 10, 0, 1);
        nf();
        ex("at_target_attack", 1, 1, 10, 8, 1);

        do_reset();
        do_spawn(100, 200, 100, 0);
        nf();
        for (int i = 1; i <= 49; i++) nf();
        ex("walk_49", 1, 100, 102, 4, 1);
        kill = 1'b1; new_frame = 1'b1;
        cyc();
        kill = 1'b0; new_frame = 1'b0;
        ex("kill_step50", 1, 100, 100, 4, 1);
        nf();
        ex("kill_over_attack", 1, 100, 100, 16, 1);

        @(negedge clk_pixel);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
